// File: rtl/ms_timer_pkg.sv
// Shared types and constants for the millisecond timer and its tick source.
package ms_timer_pkg;

  localparam int unsigned MS_W_DEFAULT = 16;
  // Tick generator period in clk cycles; its counter wraps at TICK_WRAP.
  localparam int unsigned TICKS_PER_MS = 5001;
  localparam int unsigned TICK_WRAP    = TICKS_PER_MS - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/ms_down_counter.sv
// Loadable down counter with zero flag; holds at zero instead of underflowing.
module ms_down_counter
  import ms_timer_pkg::*;
#(
  parameter int unsigned W = MS_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/ms_timer.sv
// Programmable millisecond countdown timer driven by the 1 ms tick pulse.
// Define MS_TIMER_AUTORELOAD_EN for periodic done (reload on expiry).
module ms_timer
  import ms_timer_pkg::*;
#(
  parameter int unsigned MS_W = MS_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ms_tick,
  input  logic            start,
  input  logic [MS_W-1:0] duration,
  input  logic            pause,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [MS_W-1:0] remaining,
  output logic [MS_W-1:0] elapsed
);

  state_e          state_q, state_d;
  logic [MS_W-1:0] dur_q, dur_d;
  logic [MS_W-1:0] elapsed_q, elapsed_d;
  logic            done_q, done_d;

  logic            accept, zero_start, count_en, expire, aborting, reload;
  logic [MS_W-1:0] rem;
  logic            rem_zero, last;

  assign last = (rem == MS_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    zero_start = 1'b0;
    count_en   = 1'b0;
    aborting   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (duration == '0) begin
            zero_start = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (abort) begin
          aborting = 1'b1;
          state_d  = IDLE;
        end else if (pause) begin
          state_d = PAUSED;
        end else if (ms_tick) begin
          count_en = !rem_zero;
        end
      end
      PAUSED: begin
        if (abort) begin
          aborting = 1'b1;
          state_d  = IDLE;
        end else if (!pause) begin
          state_d  = RUN;
          count_en = ms_tick && !rem_zero;
        end
      end
      default: state_d = IDLE;
    endcase
    expire = count_en && last;
`ifdef MS_TIMER_AUTORELOAD_EN
    reload = expire;
`else
    reload = 1'b0;
    if (expire) begin
      state_d = IDLE;
    end
`endif
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
  end

  always_comb begin
    dur_d     = (state_q == IDLE && start) ? duration : dur_q;
    done_d    = expire || zero_start;
    elapsed_d = elapsed_q;
    if (accept || zero_start) begin
      elapsed_d = '0;
    end else if (expire) begin
`ifdef MS_TIMER_AUTORELOAD_EN
      elapsed_d = '0;
`else
      elapsed_d = dur_q;
`endif
    end else if (count_en) begin
      elapsed_d = elapsed_q + MS_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dur_q     <= '0;
      elapsed_q <= '0;
      done_q    <= 1'b0;
    end else begin
      dur_q     <= dur_d;
      elapsed_q <= elapsed_d;
      done_q    <= done_d;
    end
  end

  // Reload has priority over the decrement issued on the same expiring tick.
  ms_down_counter #(.W(MS_W)) u_remaining (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (aborting || zero_start),
    .load_i     (accept || reload),
    .load_val_i (accept ? duration : dur_q),
    .dec_i      (count_en),
    .count_o    (rem),
    .zero_o     (rem_zero)
  );

  assign remaining = rem;
  assign elapsed   = elapsed_q;

endmodule

// File: tb/tb_ms_timer.sv
// Scoreboard bench for ms_timer: stimulus queues expected done events, a monitor checks them.
module tb_ms_timer;
  import ms_timer_pkg::*;

  localparam int unsigned W = 16;
`ifdef MS_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ms_tick = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] duration = '0;
  logic         busy, done;
  logic [W-1:0] remaining, elapsed;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    string name;
    int    cyc;
    int    el;
    int    rem;
    int    busy;
  } exp_t;

  exp_t sb[$];

  ms_timer #(.MS_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .ms_tick   (ms_tick),
    .start     (start),
    .duration  (duration),
    .pause     (pause),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .remaining (remaining),
    .elapsed   (elapsed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int ex_el(input int dur);
    return AR ? 0 : dur;
  endfunction

  function automatic int ex_rem(input int dur);
    return AR ? dur : 0;
  endfunction

  // Called at a negedge just before the edge expected to raise done.
  task automatic push_done(input string name, input int el, input int rem, input int b);
    exp_t e;
    e.name = name;
    e.cyc  = cyc + 1;
    e.el   = el;
    e.rem  = rem;
    e.busy = b;
    sb.push_back(e);
  endtask

  task automatic tick_pulse(input int gap, input bit exp_done, input string name,
                            input int el, input int rem, input int b);
    repeat (gap) @(negedge clk);
    ms_tick = 1'b1;
    if (exp_done) push_done(name, el, rem, b);
    @(negedge clk);
    ms_tick = 1'b0;
  endtask

  task automatic do_start(input int dur);
    start    = 1'b1;
    duration = W'(dur);
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic end_run();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected done=0", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_cycle"},   cyc,            e.cyc);
        chk({e.name, "_elapsed"}, int'(elapsed),  e.el);
        chk({e.name, "_remain"},  int'(remaining), e.rem);
        chk({e.name, "_busy"},    int'(busy),     e.busy);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_remaining", int'(remaining), 0);
    chk("rst_elapsed", int'(elapsed), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Duration 3 at the real tick rate.
    do_start(3);
    chk("t1_busy", int'(busy), 1);
    chk("t1_rem0", int'(remaining), 3);
    chk("t1_el0", int'(elapsed), 0);
    for (int k = 1; k <= 3; k++) begin
      tick_pulse(int'(TICKS_PER_MS) - 1, k == 3, "t1_done", ex_el(3), ex_rem(3), int'(AR));
      if (k < 3) chk($sformatf("t1_rem_k%0d", k), int'(remaining), 3 - k);
    end
    chk("t1_busy_end", int'(busy), int'(AR));
    end_run();
    chk("t1_idle_abort_el", int'(elapsed), ex_el(3));
    chk("t1_idle_abort_busy", int'(busy), 0);

    // Zero duration: single done, never busy.
    start    = 1'b1;
    duration = '0;
    push_done("t2_done", 0, 0, 0);
    @(negedge clk);
    start = 1'b0;
    chk("t2_busy", int'(busy), 0);
    chk("t2_el", int'(elapsed), 0);
    repeat (3) @(negedge clk);
    chk("t2_busy_later", int'(busy), 0);

    // Pause: ticks coinciding with or during pause are lost.
    do_start(5);
    tick_pulse(3, 1'b0, "", 0, 0, 0);
    chk("t3_rem_a", int'(remaining), 4);
    pause = 1'b1;
    tick_pulse(0, 1'b0, "", 0, 0, 0);
    tick_pulse(3, 1'b0, "", 0, 0, 0);
    chk("t3_rem_paused", int'(remaining), 4);
    chk("t3_el_paused", int'(elapsed), 1);
    chk("t3_busy_paused", int'(busy), 1);
    pause = 1'b0;
    tick_pulse(0, 1'b0, "", 0, 0, 0);
    chk("t3_rem_release", int'(remaining), 3);
    tick_pulse(3, 1'b0, "", 0, 0, 0);
    tick_pulse(3, 1'b0, "", 0, 0, 0);
    chk("t3_rem_b", int'(remaining), 1);
    tick_pulse(3, 1'b1, "t3_done", ex_el(5), ex_rem(5), int'(AR));
    end_run();

    // Abort coinciding with the 4th tick; start while busy ignored.
    do_start(10);
    for (int k = 0; k < 3; k++) tick_pulse(3, 1'b0, "", 0, 0, 0);
    do_start(2);
    chk("t4_rem_ignored_start", int'(remaining), 7);
    chk("t4_busy", int'(busy), 1);
    abort = 1'b1;
    tick_pulse(0, 1'b0, "", 0, 0, 0);
    abort = 1'b0;
    chk("t4_busy_abort", int'(busy), 0);
    chk("t4_rem_abort", int'(remaining), 0);
    chk("t4_el_abort", int'(elapsed), 3);

    // Tick in the start cycle is not counted.
    start    = 1'b1;
    duration = W'(2);
    ms_tick  = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    ms_tick = 1'b0;
    chk("t5_rem0", int'(remaining), 2);
    chk("t5_el0", int'(elapsed), 0);
    tick_pulse(3, 1'b0, "", 0, 0, 0);
    chk("t5_rem1", int'(remaining), 1);
    tick_pulse(3, 1'b1, "t5_done", ex_el(2), ex_rem(2), int'(AR));
    end_run();

`ifdef MS_TIMER_AUTORELOAD_EN
    do_start(2);
    for (int k = 1; k <= 6; k++) tick_pulse(3, (k % 2) == 0, $sformatf("t6_done_k%0d", k), 0, 2, 1);
    chk("t6_busy", int'(busy), 1);
    end_run();
    chk("t6_busy_abort", int'(busy), 0);
`endif

    // Asynchronous reset mid-run.
    do_start(5);
    tick_pulse(3, 1'b0, "", 0, 0, 0);
    tick_pulse(3, 1'b0, "", 0, 0, 0);
    chk("t7_rem_pre", int'(remaining), 3);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_busy", int'(busy), 0);
    chk("t7_rst_done", int'(done), 0);
    chk("t7_rst_rem", int'(remaining), 0);
    chk("t7_rst_el", int'(elapsed), 0);
    @(negedge clk);
    rst = 1'b0;
    tick_pulse(3, 1'b0, "", 0, 0, 0);
    tick_pulse(3, 1'b0, "", 0, 0, 0);
    chk("t7_busy_after", int'(busy), 0);
    chk("t7_rem_after", int'(remaining), 0);

    repeat (5) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
